// File: rtl/simple_rand_pkg.sv
// -----------------------------------------------------------------------------
// simple_rand_pkg
//   Shared constants and helpers for the simple_rand pseudo-random generator.
//   - LFSR width and Galois feedback mask (x^32 + x^22 + x^2 + x + 1)
//   - golden-ratio constant used to decorrelate per-lane seeds
//   - lfsr_next : one right-shifting Galois LFSR step
//   - seg_width : width of segment k for a range of R values cut into SPLIT
//                 segments of nominal width W (last segment takes the rest)
// -----------------------------------------------------------------------------
package simple_rand_pkg;

    localparam int                LFSR_W         = 32;
    localparam logic [LFSR_W-1:0] LFSR_MASK      = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] LANE_SEED_STEP = 32'h9E37_79B9;

    // A non-zero state can never step to zero: when the LSB is set the mask
    // forces bit 31 high, otherwise a plain shift of a non-zero value whose
    // LSB is clear stays non-zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        if (s[0]) begin
            return (s >> 1) ^ LFSR_MASK;
        end
        return s >> 1;
    endfunction

    function automatic int seg_width(input int k, input int r, input int w, input int split);
        if (k == split - 1) begin
            return r - (split - 1) * w;
        end
        return w;
    endfunction

endpackage

// File: rtl/simple_rand_lane.sv
// -----------------------------------------------------------------------------
// simple_rand_lane
//   One lane of the simple_rand generator: a 32-bit Galois LFSR, a segment
//   counter that walks every segment once per SPLIT cycles, and the
//   registered output value BEGIN_VALUE + seg*W + (lfsr[15:0] mod width(seg)).
//
//   Optional feature macro: SIMPLE_RAND_HOLD_EN (adds the hold input).
//
// Ports
//   clock      in   rising-edge clock
//   rst        in   synchronous active-high reset
//   hold       in   (SIMPLE_RAND_HOLD_EN only) freeze lfsr, seg and output
//   rand_data  out  DSIZE-bit registered lane value
// -----------------------------------------------------------------------------
module simple_rand_lane
    import simple_rand_pkg::*;
#(
    parameter int          BEGIN_VALUE = 0,
    parameter int          END_VALUE   = 100,
    parameter int          SPLIT       = 10,
    parameter int          DSIZE       = 8,
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter int          LANE_IDX    = 0
) (
    input  logic             clock,
    input  logic             rst,
`ifdef SIMPLE_RAND_HOLD_EN
    input  logic             hold,
`endif
    output logic [DSIZE-1:0] rand_data
);

    localparam int R      = END_VALUE - BEGIN_VALUE + 1;
    localparam int W      = (R + SPLIT - 1) / SPLIT;
    localparam int WL     = seg_width(SPLIT - 1, R, W, SPLIT);
    // Keeps the modulo well-defined while the top reports a bad WL.
    localparam int WL_DIV = (WL > 0) ? WL : 1;
    localparam int SEG_W  = (SPLIT > 1) ? $clog2(SPLIT) : 1;

    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(SPLIT - 1);
    localparam logic [SEG_W-1:0]  SEG_INIT  = SEG_W'(LANE_IDX % SPLIT);
    localparam logic [31:0]       SEED_MIX  = SEED ^ (32'(LANE_IDX) * LANE_SEED_STEP);
    localparam logic [31:0]       LFSR_INIT = (SEED_MIX == 32'h0) ? 32'h1 : SEED_MIX;
    localparam logic [DSIZE-1:0]  BEGIN_D   = DSIZE'(BEGIN_VALUE);

    // Both remainders use constant divisors; the segment index only picks
    // which one is used, so no run-time divider is built.
    function automatic logic [DSIZE-1:0] seg_value(input logic [SEG_W-1:0] s,
                                                    input logic [15:0]      r);
        logic [31:0] off_mid;
        logic [31:0] off_last;
        logic [31:0] off;
        logic [31:0] base;
        off_mid  = {16'h0, r} % 32'(W);
        off_last = {16'h0, r} % 32'(WL_DIV);
        off      = (s == SEG_LAST) ? off_last : off_mid;
        base     = 32'(BEGIN_VALUE) + 32'(s) * 32'(W);
        return DSIZE'(base + off);
    endfunction

    logic [31:0]      lfsr_p0;
    logic [SEG_W-1:0] seg_p0;
    logic [SEG_W-1:0] seg_next;
    logic             advance;

`ifdef SIMPLE_RAND_HOLD_EN
    assign advance = ~hold;
`else
    assign advance = 1'b1;
`endif

    assign seg_next = (seg_p0 == SEG_LAST) ? '0 : seg_p0 + SEG_W'(1);

    // Stage p0: LFSR/segment state and registered lane output
    always_ff @(posedge clock) begin
        if (rst) begin
            lfsr_p0   <= LFSR_INIT;
            seg_p0    <= SEG_INIT;
            rand_data <= BEGIN_D;
        end else if (advance) begin
            lfsr_p0   <= lfsr_next(lfsr_p0);
            seg_p0    <= seg_next;
            rand_data <= seg_value(seg_p0, lfsr_p0[15:0]);
        end
    end

endmodule

// File: rtl/simple_rand.sv
// -----------------------------------------------------------------------------
// simple_rand
//   Free-running pseudo-random stimulus source. NUM independent lanes each
//   emit one DSIZE-bit value per clock inside [BEGIN_VALUE, END_VALUE]. The
//   range is cut into SPLIT segments; each lane visits every segment once per
//   SPLIT cycles and picks an LFSR-derived offset inside it. Lane i starts at
//   segment i mod SPLIT with a seed decorrelated by the golden-ratio constant.
//
//   Optional feature macro: SIMPLE_RAND_HOLD_EN (adds the hold input; when
//   high and rst low, every lane keeps its state and output).
//
// Ports
//   clock      in   rising-edge clock
//   rst        in   synchronous active-high reset (wins over hold)
//   hold       in   (SIMPLE_RAND_HOLD_EN only) freeze the generator
//   rand_data  out  NUM*DSIZE packed lanes, lane i at [i*DSIZE +: DSIZE]
// -----------------------------------------------------------------------------
module simple_rand
    import simple_rand_pkg::*;
#(
    parameter int          BEGIN_VALUE = 0,
    parameter int          END_VALUE   = 100,
    parameter int          SPLIT       = 10,
    parameter int          NUM         = 1,
    parameter int          DSIZE       = 8,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                 clock,
    input  logic                 rst,
`ifdef SIMPLE_RAND_HOLD_EN
    input  logic                 hold,
`endif
    output logic [NUM*DSIZE-1:0] rand_data
);

    localparam int R  = END_VALUE - BEGIN_VALUE + 1;
    localparam int W  = (SPLIT > 0) ? (R + SPLIT - 1) / SPLIT : 1;
    localparam int WL = seg_width(SPLIT - 1, R, W, SPLIT);

    if (NUM < 1) begin : g_bad_num
        $fatal(1, "simple_rand: NUM must be at least 1");
    end
    if (DSIZE < 1 || DSIZE > 32) begin : g_bad_dsize
        $fatal(1, "simple_rand: DSIZE must be in 1..32");
    end
    if (BEGIN_VALUE < 0 || END_VALUE < BEGIN_VALUE) begin : g_bad_range
        $fatal(1, "simple_rand: need 0 <= BEGIN_VALUE <= END_VALUE");
    end
    if (longint'(END_VALUE) >= (longint'(1) << DSIZE)) begin : g_bad_end
        $fatal(1, "simple_rand: END_VALUE does not fit in DSIZE bits");
    end
    if (SPLIT < 1 || SPLIT > R) begin : g_bad_split
        $fatal(1, "simple_rand: SPLIT must be in 1..END_VALUE-BEGIN_VALUE+1");
    end
    if (WL <= 0) begin : g_bad_last
        $fatal(1, "simple_rand: SPLIT leaves an empty last segment");
    end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        simple_rand_lane #(
            .BEGIN_VALUE (BEGIN_VALUE),
            .END_VALUE   (END_VALUE),
            .SPLIT       (SPLIT),
            .DSIZE       (DSIZE),
            .SEED        (SEED),
            .LANE_IDX    (i)
        ) u_lane (
            .clock       (clock),
            .rst         (rst),
`ifdef SIMPLE_RAND_HOLD_EN
            .hold        (hold),
`endif
            .rand_data   (rand_data[i*DSIZE +: DSIZE])
        );
    end

endmodule

// File: tb/tb_simple_rand.sv
// -----------------------------------------------------------------------------
// tb_simple_rand
//   Directed bench for simple_rand. Four instances share clock/reset:
//   default range, a 20..37 / SPLIT=4 range, two lanes, and a single-value
//   range with SPLIT=1. Exact first values for seed 1 were worked out by
//   stepping the Galois LFSR by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_simple_rand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic [7:0]  data_def;
    logic [7:0]  data_soak;
    logic [15:0] data_multi;
    logic [7:0]  data_one;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_rand #(.BEGIN_VALUE(0), .END_VALUE(100), .SPLIT(10), .NUM(1), .DSIZE(8),
                  .SEED(32'h0000_0001)) dut_def (
        .clock(clk), .rst(rst),
`ifdef SIMPLE_RAND_HOLD_EN
        .hold(hold),
`endif
        .rand_data(data_def));

    simple_rand #(.BEGIN_VALUE(20), .END_VALUE(37), .SPLIT(4), .NUM(1), .DSIZE(8),
                  .SEED(32'h0000_0001)) dut_soak (
        .clock(clk), .rst(rst),
`ifdef SIMPLE_RAND_HOLD_EN
        .hold(hold),
`endif
        .rand_data(data_soak));

    simple_rand #(.BEGIN_VALUE(0), .END_VALUE(100), .SPLIT(10), .NUM(2), .DSIZE(8),
                  .SEED(32'h0000_0001)) dut_multi (
        .clock(clk), .rst(rst),
`ifdef SIMPLE_RAND_HOLD_EN
        .hold(hold),
`endif
        .rand_data(data_multi));

    simple_rand #(.BEGIN_VALUE(5), .END_VALUE(5), .SPLIT(1), .NUM(1), .DSIZE(8),
                  .SEED(32'h0000_0001)) dut_one (
        .clock(clk), .rst(rst),
`ifdef SIMPLE_RAND_HOLD_EN
        .hold(hold),
`endif
        .rand_data(data_one));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst low just after the last reset edge; the next edge yields value 1.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (data_def !== 8'd0) begin
            failures++;
            $display("FAIL reset_def got=%0d expected=0", data_def);
        end
        checks++;
        if (data_soak !== 8'd20) begin
            failures++;
            $display("FAIL reset_soak got=%0d expected=20", data_soak);
        end
        checks++;
        if (data_multi !== 16'h0000) begin
            failures++;
            $display("FAIL reset_multi got=%h expected=0000", data_multi);
        end
        checks++;
        if (data_one !== 8'd5) begin
            failures++;
            $display("FAIL reset_one got=%0d expected=5", data_one);
        end
        rst = 1'b0;
    endtask

    // Called right after test_reset, so the first edge here is the first value.
    task automatic test_default_seq();
        int exp_v [11] = '{1, 14, 24, 34, 47, 57, 67, 79, 94, 100, 3};
        int lo    [10] = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99};
        int hi    [10] = '{10, 21, 32, 43, 54, 65, 76, 87, 98, 100};
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (int'(data_def) !== exp_v[i]) begin
                failures++;
                $display("FAIL default_seq[%0d] got=%0d expected=%0d", i, data_def, exp_v[i]);
            end
            checks++;
            if (int'(data_def) < lo[i % 10] || int'(data_def) > hi[i % 10]) begin
                failures++;
                $display("FAIL default_seg[%0d] got=%0d expected=%0d..%0d",
                         i, data_def, lo[i % 10], hi[i % 10]);
            end
        end
    endtask

    task automatic test_reproducibility();
        logic [7:0] rec [50];
        do_reset(1);
        for (int i = 0; i < 50; i++) begin
            step();
            rec[i] = data_def;
        end
        checks++;
        if (rec[0] !== 8'd1) begin
            failures++;
            $display("FAIL repro_first got=%0d expected=1", rec[0]);
        end
        repeat (7) step();
        rst = 1'b1;
        step();
        checks++;
        if (data_def !== 8'd0) begin
            failures++;
            $display("FAIL repro_midreset got=%0d expected=0", data_def);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if (data_def !== rec[i]) begin
                failures++;
                $display("FAIL repro[%0d] got=%0d expected=%0d", i, data_def, rec[i]);
            end
        end
    endtask

    task automatic test_multi_lane();
        int diff = 0;
        do_reset(1);
        step();
        checks++;
        if (data_multi[7:0] !== 8'd1) begin
            failures++;
            $display("FAIL multi_l0_first got=%0d expected=1", data_multi[7:0]);
        end
        checks++;
        if (data_multi[15:8] !== 8'd19) begin
            failures++;
            $display("FAIL multi_l1_first got=%0d expected=19", data_multi[15:8]);
        end
        checks++;
        if (data_multi[15:8] < 8'd11 || data_multi[15:8] > 8'd21) begin
            failures++;
            $display("FAIL multi_l1_seg got=%0d expected=11..21", data_multi[15:8]);
        end
        step();
        checks++;
        if (data_multi[7:0] !== 8'd14) begin
            failures++;
            $display("FAIL multi_l0_second got=%0d expected=14", data_multi[7:0]);
        end
        checks++;
        if (data_multi[15:8] !== 8'd25) begin
            failures++;
            $display("FAIL multi_l1_second got=%0d expected=25", data_multi[15:8]);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (data_multi[7:0] !== data_multi[15:8]) diff++;
        end
        checks++;
        if (diff < 10) begin
            failures++;
            $display("FAIL multi_differ got=%0d differing samples expected>=10", diff);
        end
    endtask

    task automatic test_soak();
        logic [17:0] seen = '0;
        int v;
        do_reset(1);
        for (int k = 0; k < 10000; k++) begin
            step();
            v = int'(data_soak);
            checks++;
            if (v < 20 || v > 37) begin
                failures++;
                $display("FAIL soak_range[%0d] got=%0d expected=20..37", k, v);
            end else begin
                seen[v - 20] = 1'b1;
            end
            if (k % 4 == 3) begin
                checks++;
                if (v < 35 || v > 37) begin
                    failures++;
                    $display("FAIL soak_last[%0d] got=%0d expected=35..37", k, v);
                end
            end
        end
        checks++;
        if (seen !== 18'h3FFFF) begin
            failures++;
            $display("FAIL soak_cover got=%h expected=3ffff", seen);
        end
    endtask

    task automatic test_split1();
        rst = 1'b1;
        step();
        checks++;
        if (data_one !== 8'd5) begin
            failures++;
            $display("FAIL split1_reset got=%0d expected=5", data_one);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (data_one !== 8'd5) begin
                failures++;
                $display("FAIL split1[%0d] got=%0d expected=5", i, data_one);
            end
        end
    endtask

`ifdef SIMPLE_RAND_HOLD_EN
    task automatic test_hold();
        int after_v [2] = '{34, 47};
        do_reset(1);
        repeat (3) step();
        checks++;
        if (data_def !== 8'd24) begin
            failures++;
            $display("FAIL hold_pre got=%0d expected=24", data_def);
        end
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (data_def !== 8'd24) begin
                failures++;
                $display("FAIL hold_keep[%0d] got=%0d expected=24", i, data_def);
            end
        end
        hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (int'(data_def) !== after_v[i]) begin
                failures++;
                $display("FAIL hold_resume[%0d] got=%0d expected=%0d", i, data_def, after_v[i]);
            end
        end
        hold = 1'b1;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (data_def !== 8'd0) begin
            failures++;
            $display("FAIL hold_rst got=%0d expected=0", data_def);
        end
        rst = 1'b0;
        step();
        checks++;
        if (data_def !== 8'd0) begin
            failures++;
            $display("FAIL hold_after_rst got=%0d expected=0", data_def);
        end
        hold = 1'b0;
        step();
        checks++;
        if (data_def !== 8'd1) begin
            failures++;
            $display("FAIL hold_first got=%0d expected=1", data_def);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_seq();
        test_reproducibility();
        test_multi_lane();
        test_split1();
        test_soak();
`ifdef SIMPLE_RAND_HOLD_EN
        test_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
